// File: rtl/lcd_hex_driver.sv
// HD44780 16x2 LCD driver: power-up init, then repaints PC and Result as hex.
// Optional build macro LCD_SKIP_UNCHANGED_EN: repaint only when inputs change.
module lcd_hex_driver #(
   parameter int T_PWRUP = 750000,
   parameter int T_CMD   = 2000,
   parameter int T_CLR   = 82000,
   parameter int T_EPW   = 12
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] PC,
   input  logic [31:0] Result,
   output logic        LCD_RS,
   output logic        LCD_RW,
   output logic        LCD_E,
   output logic [7:0]  LCD_DATA,
   output logic        READY
);

   localparam int M1 = (T_PWRUP > T_CLR) ? T_PWRUP : T_CLR;
   localparam int M2 = (M1 > T_CMD) ? M1 : T_CMD;
   localparam int M3 = (M2 > T_EPW) ? M2 : T_EPW;
   localparam int DW = $clog2(M3 + 1);

   localparam logic [DW-1:0] D_PWRUP = DW'(T_PWRUP - 1);
   localparam logic [DW-1:0] D_CMD   = DW'(T_CMD - 1);
   localparam logic [DW-1:0] D_CLR   = DW'(T_CLR - 1);
   localparam logic [DW-1:0] D_EPW   = DW'(T_EPW - 1);

   typedef enum logic [2:0] {
      S_PWRUP, S_INIT, S_SNAP, S_LINE1, S_LINE2
   } state_t;

   typedef enum logic [1:0] {
      P_SETUP, P_STROBE, P_WAIT
   } phase_t;

   state_t        state, n_state;
   phase_t        ph, n_ph;
   logic [3:0]    idx, n_idx;
   logic [DW-1:0] dly, n_dly;
   logic          ready_q, n_ready;
   logic [31:0]   sh_pc, n_pc;
   logic [31:0]   sh_res, n_res;
`ifdef LCD_SKIP_UNCHANGED_EN
   logic          shown, n_shown;
`endif

   logic          writing;
   logic          cur_rs;
   logic [7:0]    cur_byte;
   logic [31:0]   word;
   logic [2:0]    nsel;
   logic          t_long;

   function automatic logic [7:0] hex(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   // Select the byte and RS level for the write currently in progress.
   always_comb begin
      cur_rs   = 1'b0;
      cur_byte = 8'h00;
      word     = (state == S_LINE1) ? sh_pc : sh_res;
      nsel     = 3'(4'd11 - idx);
      case (state)
         S_INIT: begin
            unique case (idx)
               4'd0, 4'd1, 4'd2: cur_byte = 8'h38;
               4'd3:             cur_byte = 8'h0C;
               4'd4:             cur_byte = 8'h01;
               default:          cur_byte = 8'h06;
            endcase
         end
         S_LINE1, S_LINE2: begin
            cur_rs = (idx != 4'd0);
            unique case (idx)
               4'd0: cur_byte = (state == S_LINE1) ? 8'h80 : 8'hC0;
               4'd1: cur_byte = (state == S_LINE1) ? 8'h50 : 8'h52;
               4'd2: cur_byte = (state == S_LINE1) ? 8'h43 : 8'h53;
               4'd3: cur_byte = 8'h3A;
               default: cur_byte = hex(word[{nsel, 2'b00} +: 4]);
            endcase
         end
         default: ;
      endcase
   end

   assign writing  = (state == S_INIT) || (state == S_LINE1) ||
                     (state == S_LINE2);
   assign t_long   = !cur_rs && (cur_byte == 8'h01);
   assign LCD_E    = writing && (ph == P_STROBE);
   assign LCD_RS   = writing && cur_rs;
   assign LCD_DATA = writing ? cur_byte : 8'h00;
   assign LCD_RW   = 1'b0;
   assign READY    = ready_q;

   // Next-state logic: sequencer plus the setup/strobe/wait write primitive.
   always_comb begin
      n_state = state;
      n_ph    = ph;
      n_idx   = idx;
      n_dly   = dly;
      n_ready = ready_q;
      n_pc    = sh_pc;
      n_res   = sh_res;
`ifdef LCD_SKIP_UNCHANGED_EN
      n_shown = shown;
`endif
      case (state)
         S_PWRUP: begin
            if (dly == '0) begin
               n_state = S_INIT;
               n_ph    = P_SETUP;
               n_idx   = 4'd0;
            end else begin
               n_dly = dly - 1'b1;
            end
         end
         S_SNAP: begin
`ifdef LCD_SKIP_UNCHANGED_EN
            if (!(shown && PC == sh_pc && Result == sh_res)) begin
               n_pc    = PC;
               n_res   = Result;
               n_state = S_LINE1;
               n_ph    = P_SETUP;
               n_idx   = 4'd0;
            end
`else
            n_pc    = PC;
            n_res   = Result;
            n_state = S_LINE1;
            n_ph    = P_SETUP;
            n_idx   = 4'd0;
`endif
         end
         default: begin
            case (ph)
               P_SETUP: begin
                  n_ph  = P_STROBE;
                  n_dly = D_EPW;
               end
               P_STROBE: begin
                  if (dly == '0) begin
                     n_ph  = P_WAIT;
                     n_dly = t_long ? D_CLR : D_CMD;
                  end else begin
                     n_dly = dly - 1'b1;
                  end
               end
               P_WAIT: begin
                  if (dly != '0) begin
                     n_dly = dly - 1'b1;
                  end else begin
                     n_ph  = P_SETUP;
                     n_idx = idx + 4'd1;
                     if (state == S_INIT && idx == 4'd5) begin
                        n_state = S_SNAP;
                        n_ready = 1'b1;
                        n_idx   = 4'd0;
                     end else if (state == S_LINE1 && idx == 4'd11) begin
                        n_state = S_LINE2;
                        n_idx   = 4'd0;
                     end else if (state == S_LINE2 && idx == 4'd11) begin
                        n_state = S_SNAP;
                        n_idx   = 4'd0;
`ifdef LCD_SKIP_UNCHANGED_EN
                        n_shown = 1'b1;
`endif
                     end
                  end
               end
               default: n_ph = P_SETUP;
            endcase
         end
      endcase
   end

   // State registers; reset aborts any write and restarts the power-up wait.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state   <= S_PWRUP;
         ph      <= P_SETUP;
         idx     <= 4'd0;
         dly     <= D_PWRUP;
         ready_q <= 1'b0;
         sh_pc   <= 32'h0;
         sh_res  <= 32'h0;
`ifdef LCD_SKIP_UNCHANGED_EN
         shown   <= 1'b0;
`endif
      end else begin
         state   <= n_state;
         ph      <= n_ph;
         idx     <= n_idx;
         dly     <= n_dly;
         ready_q <= n_ready;
         sh_pc   <= n_pc;
         sh_res  <= n_res;
`ifdef LCD_SKIP_UNCHANGED_EN
         shown   <= n_shown;
`endif
      end
   end

endmodule

// File: tb/tb_lcd_hex_driver.sv
// Bench for lcd_hex_driver: captures every LCD write and compares it
// against a string-based model of the init sequence and display frames.
module tb_lcd_hex_driver;

   localparam int T_PWRUP = 10;
   localparam int T_CMD   = 4;
   localparam int T_CLR   = 8;
   localparam int T_EPW   = 2;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [31:0] PC;
   logic [31:0] Result;
   logic        LCD_RS, LCD_RW, LCD_E, READY;
   logic [7:0]  LCD_DATA;

   int checks   = 0;
   int failures = 0;

   int          cyc = 0;
   bit          pe  = 1'b0;
   bit          pr  = 1'b0;
   logic [8:0]  wq[$];
   int          wc[$];
   int          rdy_cyc = -1;

   logic [7:0]  init_seq [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
   logic [31:0] fpc [5];
   logic [31:0] fres [5];

   lcd_hex_driver #(
      .T_PWRUP(T_PWRUP),
      .T_CMD  (T_CMD),
      .T_CLR  (T_CLR),
      .T_EPW  (T_EPW)
   ) dut (
      .CLK     (CLK),
      .RST     (RST),
      .PC      (PC),
      .Result  (Result),
      .LCD_RS  (LCD_RS),
      .LCD_RW  (LCD_RW),
      .LCD_E   (LCD_E),
      .LCD_DATA(LCD_DATA),
      .READY   (READY)
   );

   always #5 CLK = ~CLK;

   // Write capture: record RS/DATA and cycle at every rising edge of E.
   always @(negedge CLK) begin
      cyc++;
      if (LCD_E && !pe) begin
         wq.push_back({LCD_RS, LCD_DATA});
         wc.push_back(cyc);
      end
      if (READY && !pr) rdy_cyc = cyc;
      pe = LCD_E;
      pr = READY;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [8:0] model_write(input int k,
                                              input logic [31:0] pc,
                                              input logic [31:0] res);
      string       hx;
      string       s;
      logic [31:0] v;
      int          j;
      hx = "0123456789ABCDEF";
      if (k == 0)  return 9'h080;
      if (k == 12) return 9'h0C0;
      s = (k < 12) ? "PC:" : "RS:";
      v = (k < 12) ? pc : res;
      j = (k % 12) - 1;
      if (j < 3) return {1'b1, s[j]};
      return {1'b1, hx[int'((v >> (4 * (10 - j))) & 32'hF)]};
   endfunction

   task automatic wait_writes(input int n, input int budget);
      int t = 0;
      while (wq.size() < n && t < budget) begin
         @(negedge CLK);
         #1;
         t++;
      end
      chk($sformatf("wait_writes_%0d", n), 32'(wq.size() >= n), 32'd1);
   endtask

   task automatic check_init(input int base, input int c0, input string tag);
      int gap;
      wait_writes(base + 7, 2000);
      if (wq.size() >= base + 7) begin
         chk({tag, "_first_e"}, 32'(wc[base] - c0), 32'(T_PWRUP + 1));
         for (int k = 0; k < 6; k++) begin
            chk($sformatf("%s_cmd%0d", tag, k), 32'(wq[base + k]),
                {23'd0, 1'b0, init_seq[k]});
            if (k > 0) begin
               gap = 1 + T_EPW + ((init_seq[k-1] == 8'h01) ? T_CLR : T_CMD);
               chk($sformatf("%s_gap%0d", tag, k),
                   32'(wc[base + k] - wc[base + k - 1]), 32'(gap));
            end
         end
         chk({tag, "_ready"}, 32'(rdy_cyc - wc[base + 5]),
             32'(T_EPW + T_CMD));
      end
   endtask

   task automatic check_frame(input int base, input logic [31:0] pc,
                              input logic [31:0] res, input string tag);
      if (wq.size() >= base + 24) begin
         for (int k = 0; k < 24; k++) begin
            chk($sformatf("%s_w%0d", tag, k), 32'(wq[base + k]),
                32'(model_write(k, pc, res)));
         end
      end else begin
         chk({tag, "_present"}, 32'(wq.size()), 32'(base + 24));
      end
   endtask

   initial begin
      int c0;
      int fb;
      int n0;
      int base;
      bit hit;

      PC     = 32'h0040001C;
      Result = 32'hDEADBEEF;
      RST    = 1'b0;
      repeat (3) @(negedge CLK);
      #1;
      chk("rst_e",     32'(LCD_E),    32'd0);
      chk("rst_rs",    32'(LCD_RS),   32'd0);
      chk("rst_rw",    32'(LCD_RW),   32'd0);
      chk("rst_data",  32'(LCD_DATA), 32'd0);
      chk("rst_ready", 32'(READY),    32'd0);

      c0  = cyc;
      RST = 1'b1;
      check_init(0, c0, "init1");

      fb = 6;
      fpc[0] = PC;
      fres[0] = Result;
      wait_writes(fb + 15, 2000);
      Result = 32'h12345678;
      fpc[1] = PC;
      fres[1] = Result;
      wait_writes(fb + 25, 2000);
      PC     = 32'hFFFFFFFF;
      Result = 32'h00000000;
      fpc[2] = PC;
      fres[2] = Result;
      wait_writes(fb + 49, 2000);
      PC     = $urandom;
      Result = $urandom;
      if (PC == fpc[2]) PC = ~PC;
      fpc[3] = PC;
      fres[3] = Result;
      wait_writes(fb + 73, 2000);
      PC     = $urandom;
      Result = $urandom;
      if (PC == fpc[3]) PC = ~PC;
      fpc[4] = PC;
      fres[4] = Result;
      wait_writes(fb + 120, 4000);
      for (int f = 0; f < 5; f++) begin
         check_frame(fb + 24 * f, fpc[f], fres[f], $sformatf("frame%0d", f));
      end
      if (wq.size() >= fb + 25) begin
         chk("snap_gap", 32'(wc[fb + 24] - wc[fb + 23]),
             32'(2 + T_EPW + T_CMD));
      end

`ifdef LCD_SKIP_UNCHANGED_EN
      n0 = wq.size();
      repeat (250) @(negedge CLK);
      #1;
      chk("idle_after_frame", 32'(wq.size()), 32'(n0));
      PC = PC ^ 32'h1;
      wait_writes(n0 + 24, 2000);
      check_frame(n0, PC, Result, "skip_repaint");
      repeat (250) @(negedge CLK);
      #1;
      chk("idle_after_repaint", 32'(wq.size()), 32'(n0 + 24));
`else
      n0 = wq.size();
      repeat (250) @(negedge CLK);
      #1;
      chk("continuous_refresh", 32'(wq.size() >= n0 + 24), 32'd1);
      check_frame(fb + 120, fpc[4], fres[4], "frame5");
`endif

      PC  = PC ^ 32'h10;
      hit = 1'b0;
      for (int t = 0; t < 2000 && !hit; t++) begin
         @(negedge CLK);
         #1;
         if (LCD_E && LCD_RS) hit = 1'b1;
      end
      chk("found_data_strobe", 32'(hit), 32'd1);
      RST = 1'b0;
      #1;
      chk("async_e",     32'(LCD_E),    32'd0);
      chk("async_rs",    32'(LCD_RS),   32'd0);
      chk("async_data",  32'(LCD_DATA), 32'd0);
      chk("async_ready", 32'(READY),    32'd0);
      repeat (3) @(negedge CLK);
      #1;
      rdy_cyc = -1;
      base    = wq.size();
      c0      = cyc;
      RST     = 1'b1;
      check_init(base, c0, "init2");
      wait_writes(base + 30, 2000);
      check_frame(base + 6, PC, Result, "frame_after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
